// File: rtl/fetch_pkg.sv
// Shared types for the fetch buffer: FSM state encoding, default depth and
// the FIFO entry layout pairing an instruction word with its PC.
package fetch_pkg;

  localparam int FETCH_DEPTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two instruction FIFO with wrapping pointers, occupancy count and a
// synchronous clear that overrides push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      // Simultaneous push and pop leaves occupancy unchanged.
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues one imem read at a time, queues returned
// words with their PCs for decode, and discards responses made stale by a flush.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  output logic        o_stall_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_dec_ready
);

  fetch_state_e          state_q;
  logic [31:0]           addr_q;
  logic                  issue, push, pop;
  fetch_entry_t          push_data, head;
  logic                  fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  // Issue is held off during reset so the stall stays asserted throughout it.
  assign issue = !i_rst && (state_q == IDLE) && !fifo_full && !i_flush;
  assign push  = (state_q == WAIT) && i_imem_rvalid && !i_flush;
  assign pop   = !fifo_empty && i_dec_ready && !i_flush;

  assign push_data.pc    = addr_q;
  assign push_data.instr = i_imem_rdata;

  assign o_imem_req    = issue;
  assign o_imem_addr   = i_pc;
  assign o_stall_pc    = i_rst || !(issue || i_flush);
  assign o_instr_valid = (fifo_count != '0);
  assign o_instr       = head.instr;
  assign o_instr_pc    = head.pc;

  always_ff @(posedge i_clk) begin
    if (issue) addr_q <= i_pc;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (issue) state_q <= WAIT;
        WAIT: begin
          if (i_flush)            state_q <= i_imem_rvalid ? IDLE : DROP;
          else if (i_imem_rvalid) state_q <= IDLE;
        end
        // The stale response is consumed here regardless of a new flush.
        DROP: if (i_imem_rvalid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .clear_i     (i_flush),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (DEPTH=2): steady fetch, backpressure,
// flush/drop, flush with push+pop, pointer wrap and mid-request reset.
module tb_fetch_buffer;

  logic        i_clk = 1'b0;
  logic        i_rst, i_flush, i_imem_rvalid, i_dec_ready;
  logic [31:0] i_pc, i_imem_rdata;
  logic        o_stall_pc, o_imem_req, o_instr_valid;
  logic [31:0] o_imem_addr, o_instr, o_instr_pc;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  fetch_buffer #(.DEPTH(2)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_pc          (i_pc),
    .i_flush       (i_flush),
    .o_stall_pc    (o_stall_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .i_dec_ready   (i_dec_ready)
  );

  // Advance past a rising edge; inputs are then changed and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_flush = 1'b0; i_imem_rvalid = 1'b0; i_dec_ready = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_pc = 32'h0; i_imem_rvalid = 1'b0;
    i_imem_rdata = 32'h0; i_dec_ready = 1'b0;

    // Reset state
    tick(); tick(); settle();
    check("rst_req",   o_imem_req,    0);
    check("rst_stall", o_stall_pc,    1);
    check("rst_valid", o_instr_valid, 0);
    check("rst_instr", o_instr,       0);
    check("rst_ipc",   o_instr_pc,    0);

    // Steady fetch: reqs at 0,4,8 every 2 cycles, decode always ready
    i_rst = 1'b0; i_dec_ready = 1'b1; i_pc = 32'h0; settle();
    check("s_req0",   o_imem_req,  1);
    check("s_addr0",  o_imem_addr, 32'h0);
    check("s_stall0", o_stall_pc,  0);
    tick(); i_pc = 32'h4; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h13; settle();
    check("s_wait_req",   o_imem_req, 0);
    check("s_wait_stall", o_stall_pc, 1);
    tick(); i_imem_rvalid = 1'b0; settle();
    check("s_valid0", o_instr_valid, 1);
    check("s_ipc0",   o_instr_pc,    32'h0);
    check("s_instr0", o_instr,       32'h13);
    check("s_req1",   o_imem_req,    1);
    check("s_addr1",  o_imem_addr,   32'h4);
    tick(); i_pc = 32'h8; i_imem_rvalid = 1'b1; settle();
    check("s_empty", o_instr_valid, 0);
    tick(); i_imem_rvalid = 1'b0; settle();
    check("s_ipc1",  o_instr_pc,  32'h4);
    check("s_req2",  o_imem_req,  1);
    check("s_addr2", o_imem_addr, 32'h8);
    tick(); i_imem_rvalid = 1'b1; settle();
    tick(); i_imem_rvalid = 1'b0; settle();
    check("s_ipc2", o_instr_pc, 32'h8);

    // Backpressure: FIFO fills at two entries, then one pop frees a slot
    i_pc = 32'h0; do_reset(); settle();
    check("bp_addr0", o_imem_addr, 32'h0);
    tick(); i_pc = 32'h4; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h13;
    tick(); i_imem_rvalid = 1'b0; settle();
    check("bp_req1", o_imem_req, 1);
    tick(); i_pc = 32'h8; i_imem_rvalid = 1'b1;
    tick(); i_imem_rvalid = 1'b0; settle();
    check("bp_full_req",   o_imem_req,  0);
    check("bp_full_stall", o_stall_pc,  1);
    check("bp_head0",      o_instr_pc,  32'h0);
    tick(); settle();
    check("bp_hold_req", o_imem_req, 0);
    i_dec_ready = 1'b1; settle();
    check("bp_pop_req", o_imem_req, 0);
    tick(); i_dec_ready = 1'b0; settle();
    check("bp_head1", o_instr_pc,  32'h4);
    check("bp_req2",  o_imem_req,  1);
    check("bp_addr2", o_imem_addr, 32'h8);

    // Flush in WAIT: late response dropped, redirect PC fetched
    i_pc = 32'h8; do_reset(); settle();
    check("fl_addr8", o_imem_addr, 32'h8);
    tick(); i_flush = 1'b1; i_pc = 32'h100; settle();
    check("fl_stall", o_stall_pc, 0);
    check("fl_req",   o_imem_req, 0);
    tick(); i_flush = 1'b0; settle();
    check("fl_drop_req",   o_imem_req, 0);
    check("fl_drop_stall", o_stall_pc, 1);
    tick(); i_imem_rvalid = 1'b1; i_imem_rdata = 32'hDEADBEEF; settle();
    check("fl_drop_req2", o_imem_req, 0);
    tick(); i_imem_rvalid = 1'b0; settle();
    check("fl_valid", o_instr_valid, 0);
    check("fl_req3",  o_imem_req,    1);
    check("fl_addr3", o_imem_addr,   32'h100);

    // Flush coincident with rvalid and pop
    i_pc = 32'h0; do_reset();
    tick(); i_imem_rvalid = 1'b1; i_imem_rdata = 32'h11;
    tick(); i_imem_rvalid = 1'b0; i_pc = 32'h4;
    tick(); i_imem_rvalid = 1'b1; i_imem_rdata = 32'h44; i_dec_ready = 1'b1;
    i_flush = 1'b1; i_pc = 32'h200; settle();
    check("fp_valid_pre", o_instr_valid, 1);
    check("fp_stall",     o_stall_pc,    0);
    tick(); i_flush = 1'b0; i_imem_rvalid = 1'b0; i_dec_ready = 1'b0; settle();
    check("fp_valid", o_instr_valid, 0);
    check("fp_req",   o_imem_req,    1);
    check("fp_addr",  o_imem_addr,   32'h200);

    // Push and pop together at count 1, pointers wrap twice
    i_pc = 32'h10; do_reset();
    tick(); i_imem_rvalid = 1'b1; i_imem_rdata = 32'hA0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      i_pc = 32'h10 + 32'(4 * k); i_dec_ready = 1'b0; i_imem_rvalid = 1'b0; settle();
      check("pp_valid", o_instr_valid, 1);
      check("pp_req",   o_imem_req,    1);
      check("pp_head",  o_instr_pc,    32'h10 + 32'(4 * (k - 1)));
      tick(); i_imem_rvalid = 1'b1; i_imem_rdata = 32'hA0 + 32'(k); i_dec_ready = 1'b1; settle();
      check("pp_instr", o_instr, 32'hA0 + 32'(k - 1));
      tick();
    end
    i_imem_rvalid = 1'b0; i_dec_ready = 1'b1; settle();
    check("pp_last_pc",    o_instr_pc, 32'h20);
    check("pp_last_instr", o_instr,    32'hA4);
    tick(); i_dec_ready = 1'b0; settle();
    check("pp_count1", o_instr_valid, 0);

    // Reset while a request is outstanding; late rvalid ignored
    i_pc = 32'h30; do_reset();
    tick(); i_rst = 1'b1; settle();
    check("rr_req",   o_imem_req, 0);
    check("rr_stall", o_stall_pc, 1);
    tick(); i_rst = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h55; i_pc = 32'h40; settle();
    check("rr_valid", o_instr_valid, 0);
    check("rr_req2",  o_imem_req,    1);
    check("rr_addr",  o_imem_addr,   32'h40);
    tick(); i_imem_rvalid = 1'b0; settle();
    check("rr_valid2", o_instr_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the instruction FIFO entry count (power of two, >=2).
REQ-002 The block SHALL have port i_clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1, meaning a synchronous, active-high reset.
REQ-004 The block SHALL have port i_pc, input, 32, meaning the current fetch PC from the PC-generation stage.
REQ-005 The block SHALL have port i_flush, input, 1, meaning a redirect pulse coincident with the PC stage's PC-update control.
REQ-006 The block SHALL have port o_stall_pc, output, 1, meaning hold the PC stage.
REQ-007 The block SHALL have port o_imem_req, output, 1, meaning an instruction-memory read request, one-cycle pulse.
REQ-008 The block SHALL have port o_imem_addr, output, 32, meaning the read address.
REQ-009 The block SHALL have port i_imem_rvalid, input, 1, meaning read data valid.
REQ-010 The block SHALL have port i_imem_rdata, input, 32, meaning the read data.
REQ-011 The block SHALL have port o_instr_valid, output, 1, meaning an instruction is available to decode.
REQ-012 The block SHALL have port o_instr, output, 32, meaning the instruction word.
REQ-013 The block SHALL have port o_instr_pc, output, 32, meaning the PC of o_instr.
REQ-014 The block SHALL have port i_dec_ready, input, 1, meaning decode accepts this cycle.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT (one request outstanding) and DROP (outstanding request is to be discarded).
REQ-016 Issue SHALL occur when state==IDLE, count<DEPTH and !i_flush: o_imem_req=1, o_imem_addr=i_pc, next state WAIT.
REQ-017 o_stall_pc SHALL be 0 only in an issue cycle or when i_flush=1; otherwise 1, combinationally.
REQ-018 At most one request SHALL be outstanding; no issue in WAIT or DROP.
REQ-019 In WAIT with i_imem_rvalid=1 and !i_flush, {addr, rdata} SHALL be pushed and state SHALL go to IDLE; the next issue is at the earliest the following cycle.
REQ-020 o_instr_valid SHALL be (count!=0); o_instr/o_instr_pc SHALL show the FIFO head; pop SHALL occur on o_instr_valid && i_dec_ready.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-022 Push SHALL never occur when full; this is guaranteed by REQ-016.
REQ-023 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-024 i_flush SHALL clear the FIFO (count=0, pointers=0) next cycle, suppress pop and push that cycle, and take priority over all other events.
REQ-025 i_flush in WAIT without rvalid SHALL go to DROP; with rvalid the same cycle the data SHALL be discarded and state SHALL go to IDLE.
REQ-026 i_flush in IDLE or DROP SHALL leave state unchanged.
REQ-027 In DROP, i_imem_rvalid SHALL be discarded and state SHALL go to IDLE.
REQ-028 i_imem_rvalid in IDLE SHALL be ignored.

Reset
REQ-029 On i_rst=1 at a clock edge: state=IDLE, count=0, pointers=0.
REQ-030 During reset the outputs SHALL be o_imem_req=0, o_instr_valid=0 and o_stall_pc=1; o_instr and o_instr_pc SHALL read 0 (storage cleared).
REQ-031 Reset mid-transaction SHALL abandon the outstanding request; a late rvalid after reset falls under REQ-028.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum (IDLE/WAIT/DROP), the DEPTH default constant and struct fetch_entry_t {pc[31:0], instr[31:0]}.
REQ-033 Storage SHALL be sub-module fetch_fifo (push/pop/clear/full/empty/count, parameter DEPTH).

Verification
REQ-034 Reset then i_pc=0x0, rvalid one cycle after each req, rdata=0x00000013, ready=1 -> reqs at 0x0, 0x4, 0x8 every 2 cycles; o_instr_pc follows 0x0, 0x4, 0x8.
REQ-035 i_dec_ready=0, DEPTH=2 -> after two pushes (0x0, 0x4) no further req and o_stall_pc=1; then ready=1 for one cycle -> pop 0x0, and the next req issues the following cycle.
REQ-036 Flush in WAIT for addr 0x8, rvalid two cycles later with 0xDEADBEEF -> not pushed; FIFO empty; next req at the redirect PC 0x100.
REQ-037 Flush coincident with rvalid and pop -> nothing pushed or popped; count=0 next cycle; state IDLE.
REQ-038 Push and pop in the same cycle with count=1 -> count stays 1; head advances; pointer wrap after 4 cycles is checked.
REQ-039 Assert i_rst in WAIT, then rvalid -> no push; o_instr_valid=0; the first req after reset release uses the current i_pc.
